// File: rtl/vga_framebuffer_reader.sv
// ---------------------------------------------------------------------------
// VgaFramebufferReader
//
// Scan-out side of the MiniAlu video memory. Holds an 80x60 grid of 3-bit
// {R,G,B} cells, each cell covering an 8x8 pixel block, accepts cell writes
// from the CPU datapath and reads the grid back in raster order in step with
// 640x480@60Hz VGA timing (25 MHz pixel rate derived from the 50 MHz clock).
//
// Ports
//   Clock          in   system clock, 50 MHz
//   Reset          in   synchronous, active-low reset
//   iWriteEnable   in   write strobe, one cell write per asserted cycle
//   iWriteAddress  in   13-bit cell index (row*80 + col), >= 4800 ignored
//   iWriteData     in   3-bit cell colour {R,G,B}
//   VGA_HSYNC      out  horizontal sync, active-low
//   VGA_VSYNC      out  vertical sync, active-low
//   VGA_RED        out  red
//   VGA_GREEN      out  green
//   VGA_BLUE       out  blue
//   oFrameStart    out  one-Clock pulse when the outputs present pixel (0,0)
// ---------------------------------------------------------------------------
module vga_framebuffer_reader #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CELL_SHIFT = 3,
    parameter int COLS       = 80,
    parameter int ROWS       = 60
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iWriteEnable,
    input  logic [12:0] iWriteAddress,
    input  logic [2:0]  iWriteData,
    output logic        VGA_HSYNC,
    output logic        VGA_VSYNC,
    output logic        VGA_RED,
    output logic        VGA_GREEN,
    output logic        VGA_BLUE,
    output logic        oFrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int CELLS   = COLS * ROWS;

    localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0]  V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0]  H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]  V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [12:0] CELL_LIMIT   = 13'(CELLS);

    logic        pixelTick;
    logic [9:0]  hCount;
    logic [9:0]  vCount;

    logic [9:0]  rowIndex;
    logic [9:0]  colIndex;
    logic [12:0] readAddress;
    logic        visibleNow;
    logic        hSyncNow;
    logic        vSyncNow;
    logic        frameStartNow;

    logic [12:0] addrS1;
    logic        visibleS1;
    logic        hSyncS1;
    logic        vSyncS1;
    logic        frameStartS1;

    logic [2:0]  pixelS2;
    logic        visibleS2;
    logic        hSyncS2;
    logic        vSyncS2;
    logic        frameStartS2;

    logic [2:0]  frameBuffer [CELLS];

    // Pixel tick toggles every Clock, so counters move at 25 MHz. It is low
    // on the first Clock after reset so each counter value lasts two Clocks.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pixelTick <= 1'b0;
        end else begin
            pixelTick <= ~pixelTick;
        end
    end

    // Raster counters: hCount wraps at the end of a line and carries into
    // vCount, which wraps at the end of a frame.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            hCount <= 10'd0;
            vCount <= 10'd0;
        end else if (pixelTick) begin
            if (hCount == H_LAST) begin
                hCount <= 10'd0;
                if (vCount == V_LAST) begin
                    vCount <= 10'd0;
                end else begin
                    vCount <= vCount + 10'd1;
                end
            end else begin
                hCount <= hCount + 10'd1;
            end
        end
    end

    // Cell index = row*80 + col, built as row*64 + row*16 + col. The
    // shift-add is specific to an 80-cell row.
    assign rowIndex    = vCount >> CELL_SHIFT;
    assign colIndex    = hCount >> CELL_SHIFT;
    assign readAddress = 13'({rowIndex, 6'b0}) + 13'({rowIndex, 4'b0}) + 13'(colIndex);

    assign visibleNow    = (hCount < H_VIS_END) && (vCount < V_VIS_END);
    assign hSyncNow      = !((hCount >= H_SYNC_START) && (hCount < H_SYNC_END));
    assign vSyncNow      = !((vCount >= V_SYNC_START) && (vCount < V_SYNC_END));
    // Only the first of the two Clocks spent on (0,0) marks a frame start.
    assign frameStartNow = (hCount == 10'd0) && (vCount == 10'd0) && !pixelTick;

    // Stage 1: latch the read address with the timing flags. Off-screen
    // positions read cell 0 so the RAM is never addressed past its end.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            addrS1       <= 13'd0;
            visibleS1    <= 1'b0;
            hSyncS1      <= 1'b1;
            vSyncS1      <= 1'b1;
            frameStartS1 <= 1'b0;
        end else begin
            addrS1       <= visibleNow ? readAddress : 13'd0;
            visibleS1    <= visibleNow;
            hSyncS1      <= hSyncNow;
            vSyncS1      <= vSyncNow;
            frameStartS1 <= frameStartNow;
        end
    end

    // Framebuffer RAM: one write port, one synchronous read port. Contents
    // survive reset; a same-cycle read of a written cell returns old data.
    always_ff @(posedge Clock) begin
        if (Reset && iWriteEnable && (iWriteAddress < CELL_LIMIT)) begin
            frameBuffer[iWriteAddress] <= iWriteData;
        end
        pixelS2 <= frameBuffer[addrS1];
    end

    // Stage 2: carry flags alongside the RAM data so sync and colour stay
    // aligned two Clocks behind the counters.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            visibleS2    <= 1'b0;
            hSyncS2      <= 1'b1;
            vSyncS2      <= 1'b1;
            frameStartS2 <= 1'b0;
        end else begin
            visibleS2    <= visibleS1;
            hSyncS2      <= hSyncS1;
            vSyncS2      <= vSyncS1;
            frameStartS2 <= frameStartS1;
        end
    end

    // Blanking masks colour outside the visible area whatever the RAM holds.
    assign VGA_RED     = visibleS2 & pixelS2[2];
    assign VGA_GREEN   = visibleS2 & pixelS2[1];
    assign VGA_BLUE    = visibleS2 & pixelS2[0];
    assign VGA_HSYNC   = hSyncS2;
    assign VGA_VSYNC   = vSyncS2;
    assign oFrameStart = frameStartS2;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// ---------------------------------------------------------------------------
// Testbench for vga_framebuffer_reader.
// dutFull runs the real 640x480 timing and is used for line-level timing.
// dutSmall uses a shrunken raster (32x24 visible, 48x31 total) so whole
// frames fit in a short run; its every output is compared against a
// behavioural model that derives the raster position from the cycle count
// since reset release and keeps its own copy of the framebuffer.
// ---------------------------------------------------------------------------
module tb_vga_framebuffer_reader;

    localparam int S_HV = 32, S_HF = 4, S_HS = 8, S_HB = 4;
    localparam int S_VV = 24, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
    localparam int FRAME_CLK = 2 * S_HT * S_VT;
    localparam int CELLS = 4800;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iWriteEnable = 1'b0;
    logic [12:0] iWriteAddress = 13'd0;
    logic [2:0]  iWriteData = 3'd0;

    logic fHsync, fVsync, fRed, fGreen, fBlue, fFrameStart;
    logic sHsync, sVsync, sRed, sGreen, sBlue, sFrameStart;
    logic [2:0] sRgb;
    logic [2:0] fRgb;
    assign sRgb = {sRed, sGreen, sBlue};
    assign fRgb = {fRed, fGreen, fBlue};

    int errorCount = 0;
    int checkCount = 0;
    int n = 0;

    logic [2:0] fbModel [CELLS];
    logic       pendValid = 1'b0;
    int         pendAddr = 0;
    logic [2:0] pendData = 3'd0;

    logic       expHs, expVs, expFs;
    logic [2:0] expRgb;

    always #5 Clock = ~Clock;

    vga_framebuffer_reader dutFull (
        .Clock(Clock), .Reset(Reset),
        .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress), .iWriteData(iWriteData),
        .VGA_HSYNC(fHsync), .VGA_VSYNC(fVsync),
        .VGA_RED(fRed), .VGA_GREEN(fGreen), .VGA_BLUE(fBlue),
        .oFrameStart(fFrameStart)
    );

    vga_framebuffer_reader #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dutSmall (
        .Clock(Clock), .Reset(Reset),
        .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress), .iWriteData(iWriteData),
        .VGA_HSYNC(sHsync), .VGA_VSYNC(sVsync),
        .VGA_RED(sRed), .VGA_GREEN(sGreen), .VGA_BLUE(sBlue),
        .oFrameStart(sFrameStart)
    );

    // Advance one Clock. The model framebuffer lags by one edge so that,
    // after this returns, it holds what the RAM held when it was read.
    task automatic stepClock();
        @(posedge Clock);
        if (pendValid) fbModel[pendAddr] = pendData;
        pendValid = Reset && iWriteEnable && (int'(iWriteAddress) < CELLS);
        pendAddr  = int'(iWriteAddress);
        pendData  = iWriteData;
        if (!Reset) n = 0;
        else n = n + 1;
        #1;
    endtask

    // Expected small-raster outputs n Clocks after reset release: the pixel
    // shown is the one the counters held two Clocks earlier.
    task automatic computeExpected();
        int p, h, v;
        if (n < 2) begin
            expHs = 1'b1; expVs = 1'b1; expFs = 1'b0; expRgb = 3'b000;
        end else begin
            p = (n - 2) / 2;
            h = p % S_HT;
            v = (p / S_HT) % S_VT;
            expHs = !(h >= S_HV + S_HF && h < S_HV + S_HF + S_HS);
            expVs = !(v >= S_VV + S_VF && v < S_VV + S_VF + S_VS);
            expFs = (h == 0) && (v == 0) && (n % 2 == 0);
            expRgb = (h < S_HV && v < S_VV) ? fbModel[(v / 8) * 80 + h / 8] : 3'b000;
        end
    endtask

    function automatic bit isFirstOf(int m, int hh, int vv);
        int p;
        if (m < 2 || (m % 2) != 0) return 1'b0;
        p = (m - 2) / 2;
        return ((p % S_HT) == hh) && (((p / S_HT) % S_VT) == vv);
    endfunction

    // Step until the next Clock will present the first cycle of pixel (hh,vv).
    task automatic gotoBefore(input int hh, input int vv);
        bit found = 1'b0;
        for (int i = 0; i < FRAME_CLK + 10; i++) begin
            if (!found) begin
                if (isFirstOf(n + 1, hh, vv)) found = 1'b1;
                else stepClock();
            end
        end
        if (!found) begin
            checkCount++; errorCount++;
            $display("[TB] FAIL goto_pixel (%0d,%0d): not reached, n=%0d", hh, vv, n);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        iWriteEnable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stepClock();
            checkCount++;
            if ({fHsync, fVsync, fFrameStart, fRgb} !== 6'b110000) begin
                errorCount++;
                $display("[TB] FAIL reset_full cycle %0d: got %b want 110000", i,
                         {fHsync, fVsync, fFrameStart, fRgb});
            end
            checkCount++;
            if ({sHsync, sVsync, sFrameStart, sRgb} !== 6'b110000) begin
                errorCount++;
                $display("[TB] FAIL reset_small cycle %0d: got %b want 110000", i,
                         {sHsync, sVsync, sFrameStart, sRgb});
            end
        end
    endtask

    task automatic test_timing_full();
        int fall1 = -1, fall2 = -1, rise1 = -1, fs1 = -1, vsLow = 0;
        logic prevH = 1'b1;
        Reset = 1'b1;
        for (int i = 0; i < 3600; i++) begin
            stepClock();
            if (prevH && !fHsync) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!prevH && fHsync && fall1 >= 0 && rise1 < 0) rise1 = n;
            if (fFrameStart && fs1 < 0) fs1 = n;
            if (!fVsync) vsLow++;
            prevH = fHsync;
        end
        checkCount++;
        if (fall1 != 2 + 2 * 656) begin
            errorCount++;
            $display("[TB] FAIL full_hsync_first_fall: got %0d want %0d", fall1, 2 + 2 * 656);
        end
        checkCount++;
        if (rise1 - fall1 != 192) begin
            errorCount++;
            $display("[TB] FAIL full_hsync_low: got %0d want 192", rise1 - fall1);
        end
        checkCount++;
        if (fall2 - fall1 != 1600) begin
            errorCount++;
            $display("[TB] FAIL full_line_period: got %0d want 1600", fall2 - fall1);
        end
        checkCount++;
        if (fs1 != 2) begin
            errorCount++;
            $display("[TB] FAIL full_first_frame_start: got %0d want 2", fs1);
        end
        checkCount++;
        if (vsLow != 0) begin
            errorCount++;
            $display("[TB] FAIL full_vsync_idle: got %0d low cycles want 0", vsLow);
        end
    endtask

    task automatic test_timing_small();
        int hFall1 = -1, hFall2 = -1, hRise = -1, vFall = -1, vRise = -1;
        int fs1 = -1, fs2 = -1, fsDouble = 0;
        logic prevH, prevV, prevF;
        prevH = sHsync; prevV = sVsync; prevF = sFrameStart;
        for (int i = 0; i < 2 * FRAME_CLK + 100; i++) begin
            stepClock();
            if (prevH && !sHsync) begin
                if (hFall1 < 0) hFall1 = n;
                else if (hFall2 < 0) hFall2 = n;
            end
            if (!prevH && sHsync && hFall1 >= 0 && hRise < 0) hRise = n;
            if (prevV && !sVsync && vFall < 0) vFall = n;
            if (!prevV && sVsync && vFall >= 0 && vRise < 0) vRise = n;
            if (sFrameStart && !prevF) begin
                if (fs1 < 0) fs1 = n;
                else if (fs2 < 0) fs2 = n;
            end
            if (sFrameStart && prevF) fsDouble++;
            prevH = sHsync; prevV = sVsync; prevF = sFrameStart;
        end
        checkCount++;
        if (hRise - hFall1 != 2 * S_HS) begin
            errorCount++;
            $display("[TB] FAIL small_hsync_low: got %0d want %0d", hRise - hFall1, 2 * S_HS);
        end
        checkCount++;
        if (hFall2 - hFall1 != 2 * S_HT) begin
            errorCount++;
            $display("[TB] FAIL small_line_period: got %0d want %0d", hFall2 - hFall1, 2 * S_HT);
        end
        checkCount++;
        if (vRise - vFall != 2 * S_VS * S_HT) begin
            errorCount++;
            $display("[TB] FAIL small_vsync_low: got %0d want %0d", vRise - vFall, 2 * S_VS * S_HT);
        end
        checkCount++;
        if (fs2 - fs1 != FRAME_CLK) begin
            errorCount++;
            $display("[TB] FAIL small_frame_period: got %0d want %0d", fs2 - fs1, FRAME_CLK);
        end
        checkCount++;
        if (fsDouble != 0) begin
            errorCount++;
            $display("[TB] FAIL small_frame_start_width: got %0d wide pulses want 0", fsDouble);
        end
    endtask

    task automatic test_fill();
        for (int a = 0; a < CELLS; a++) begin
            iWriteEnable = 1'b1;
            iWriteAddress = 13'(a);
            iWriteData = 3'($urandom);
            stepClock();
        end
        iWriteEnable = 1'b0;
        stepClock();
        stepClock();
    endtask

    task automatic test_raster();
        for (int i = 0; i < FRAME_CLK + 4; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                iWriteEnable = 1'b1;
                if ($urandom_range(0, 3) == 0) iWriteAddress = 13'($urandom);
                else iWriteAddress = 13'($urandom_range(0, 2) * 80 + $urandom_range(0, 3));
                iWriteData = 3'($urandom);
            end else begin
                iWriteEnable = 1'b0;
            end
            stepClock();
            computeExpected();
            checkCount++;
            if ({sHsync, sVsync, sFrameStart} !== {expHs, expVs, expFs}) begin
                errorCount++;
                $display("[TB] FAIL raster_sync n=%0d: got %b want %b", n,
                         {sHsync, sVsync, sFrameStart}, {expHs, expVs, expFs});
            end
            checkCount++;
            if (sRgb !== expRgb) begin
                errorCount++;
                $display("[TB] FAIL raster_rgb n=%0d: got %b want %b", n, sRgb, expRgb);
            end
        end
        iWriteEnable = 1'b0;
        stepClock();
        stepClock();
    endtask

    task automatic test_cell_write();
        logic [2:0] prior1;
        prior1 = fbModel[1];
        iWriteEnable = 1'b1; iWriteAddress = 13'd0;  iWriteData = 3'b100;
        stepClock();
        iWriteAddress = 13'd81; iWriteData = 3'b010;
        stepClock();
        iWriteEnable = 1'b0;
        gotoBefore(0, 0); stepClock();
        checkCount++;
        if ({sFrameStart, sRgb} !== 4'b1100) begin
            errorCount++;
            $display("[TB] FAIL cell_red_00 fs,rgb: got %b want 1100", {sFrameStart, sRgb});
        end
        gotoBefore(8, 0); stepClock();
        checkCount++;
        if (sRgb !== prior1) begin
            errorCount++;
            $display("[TB] FAIL cell_prior_80: got %b want %b", sRgb, prior1);
        end
        gotoBefore(7, 7); stepClock();
        checkCount++;
        if (sRgb !== 3'b100) begin
            errorCount++;
            $display("[TB] FAIL cell_red_77: got %b want 100", sRgb);
        end
        gotoBefore(8, 8); stepClock();
        checkCount++;
        if (sRgb !== 3'b010) begin
            errorCount++;
            $display("[TB] FAIL cell_green_88: got %b want 010", sRgb);
        end
        gotoBefore(15, 15); stepClock();
        checkCount++;
        if (sRgb !== 3'b010) begin
            errorCount++;
            $display("[TB] FAIL cell_green_1515: got %b want 010", sRgb);
        end
    endtask

    task automatic test_out_of_range();
        iWriteEnable = 1'b1; iWriteData = 3'b111;
        iWriteAddress = 13'd4800;
        stepClock();
        iWriteAddress = 13'd8191;
        stepClock();
        iWriteEnable = 1'b0;
        for (int i = 0; i < FRAME_CLK; i++) begin
            stepClock();
            computeExpected();
            checkCount++;
            if ({sHsync, sVsync, sFrameStart, sRgb} !== {expHs, expVs, expFs, expRgb}) begin
                errorCount++;
                $display("[TB] FAIL out_of_range_frame n=%0d: got %b want %b", n,
                         {sHsync, sVsync, sFrameStart, sRgb}, {expHs, expVs, expFs, expRgb});
            end
        end
    endtask

    task automatic test_back_to_back_same_cell();
        logic [2:0] oldVal, newVal;
        stepClock();
        stepClock();
        oldVal = fbModel[0];
        newVal = ~oldVal;
        gotoBefore(0, 0);
        iWriteEnable = 1'b1; iWriteAddress = 13'd0; iWriteData = newVal;
        stepClock();
        iWriteEnable = 1'b0;
        checkCount++;
        if (sRgb !== oldVal) begin
            errorCount++;
            $display("[TB] FAIL same_cycle_old: got %b want %b", sRgb, oldVal);
        end
        stepClock();
        checkCount++;
        if (sRgb !== newVal) begin
            errorCount++;
            $display("[TB] FAIL same_cycle_next_read: got %b want %b", sRgb, newVal);
        end
        gotoBefore(0, 1); stepClock();
        checkCount++;
        if (sRgb !== newVal) begin
            errorCount++;
            $display("[TB] FAIL same_cycle_next_line: got %b want %b", sRgb, newVal);
        end
    endtask

    task automatic test_mid_reset();
        int fsAt = -1;
        stepClock();
        stepClock();
        gotoBefore(20, 10); stepClock();
        Reset = 1'b0;
        iWriteEnable = 1'b1; iWriteAddress = 13'd0; iWriteData = ~fbModel[0];
        for (int i = 0; i < 2; i++) begin
            stepClock();
            checkCount++;
            if ({sHsync, sVsync, sFrameStart, sRgb} !== 6'b110000) begin
                errorCount++;
                $display("[TB] FAIL mid_reset_small cycle %0d: got %b want 110000", i,
                         {sHsync, sVsync, sFrameStart, sRgb});
            end
            checkCount++;
            if ({fHsync, fVsync, fFrameStart, fRgb} !== 6'b110000) begin
                errorCount++;
                $display("[TB] FAIL mid_reset_full cycle %0d: got %b want 110000", i,
                         {fHsync, fVsync, fFrameStart, fRgb});
            end
        end
        Reset = 1'b1;
        iWriteEnable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (fsAt < 0) begin
                stepClock();
                if (sFrameStart) fsAt = n;
            end
        end
        checkCount++;
        if (fsAt != 2) begin
            errorCount++;
            $display("[TB] FAIL mid_reset_frame_start: got %0d want 2", fsAt);
        end
        for (int i = 0; i < FRAME_CLK; i++) begin
            stepClock();
            computeExpected();
            checkCount++;
            if ({sHsync, sVsync, sFrameStart, sRgb} !== {expHs, expVs, expFs, expRgb}) begin
                errorCount++;
                $display("[TB] FAIL mid_reset_frame n=%0d: got %b want %b", n,
                         {sHsync, sVsync, sFrameStart, sRgb}, {expHs, expVs, expFs, expRgb});
            end
        end
    endtask

    // Runs the scenarios in order; each leaves the raster running for the next.
    initial begin
        test_reset();
        test_timing_full();
        test_timing_small();
        test_fill();
        test_raster();
        test_cell_write();
        test_out_of_range();
        test_back_to_back_same_cell();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    // Guards against a stall anywhere in the sequence above.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, n=%0d", n);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
